// File: rtl/div_iter.sv
// Radix-2 restoring divider answering the ALU start/annul/ready handshake.
// Returns {remainder, quotient} with a one-cycle ready_o pulse.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic                 b_msb_q, b_msb_d;
   logic                 sgn_q, sgn_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;

   logic [WIDTH:0]       rem_sh, diff, rem_nx;
   logic [WIDTH-1:0]     quo_nx, q_fix, r_fix;
   logic                 abort;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      a_d      = a_q;
      b_msb_d  = b_msb_q;
      sgn_d    = sgn_q;
      result_d = result_q;
      abort    = annul_i | ~start_i;

      // quo_q doubles as the dividend shift register: its MSB feeds the remainder
      rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      if (diff[WIDTH]) begin
         rem_nx = rem_sh;
         quo_nx = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_nx = diff;
         quo_nx = {quo_q[WIDTH-2:0], 1'b1};
      end
      q_fix = (sgn_q & (a_q[WIDTH-1] ^ b_msb_q)) ? -quo_nx : quo_nx;
      r_fix = (sgn_q & a_q[WIDTH-1]) ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

      case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               a_d     = a;
               b_msb_d = b[WIDTH-1];
               sgn_d   = signed_div_i;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = (signed_div_i && a[WIDTH-1]) ? -a : a;
               dvs_d   = (signed_div_i && b[WIDTH-1]) ? -b : b;
               state_d = (b == '0) ? S_DIVZERO : S_ON;
            end
         end
         S_DIVZERO: begin
            if (abort) state_d = S_IDLE;
            else begin
               state_d  = S_END;
               result_d = {a_q, {WIDTH{1'b1}}};
            end
         end
         S_ON: begin
            if (abort) state_d = S_IDLE;
            else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d  = S_END;
                  result_d = {r_fix, q_fix};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_END);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         a_q      <= '0;
         b_msb_q  <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         a_q      <= a_d;
         b_msb_q  <= b_msb_d;
         sgn_q    <= sgn_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
